shot_controller: RTL

- Upstream stage that drives trajectory_calc. Turns debounced player buttons into a player position, aim (rise/run/direction), a one-cycle shoot pulse and a pseudo-random target.
- Consumes trajectory_calc's result_valid/hit to keep score and a shot budget, and to sequence rounds through to game over.

---
 rtl/shot_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/shot_controller.sv
// Player-side front end for trajectory_calc: turns button edges into aim settings and a
// one-cycle shoot pulse, then keeps score, shot budget and the pseudo-random target.
module shot_controller #(
    parameter int          SHOTS        = 3,
    parameter logic [4:0]  LFSR_SEED    = 5'h15,
    parameter int          WAIT_TIMEOUT = 63,
    parameter int          RUN_MAX      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_fire,
    input  logic       btn_dir,
    input  logic       aim_sel,
    input  logic       result_valid,
    input  logic       hit,
    output logic [4:0] x_pos,
    output logic [4:0] rise_out,
    output logic [4:0] run_out,
    output logic       direction_out,
    output logic       shoot,
    output logic [4:0] target_x,
    output logic [4:0] target_y,
    output logic [7:0] score,
    output logic [2:0] shots_left,
    output logic       busy,
    output logic       game_over
);

    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_AIM,
        S_FIRE,
        S_WAIT,
        S_SCORE,
        S_OVER
    } state_t;

    typedef struct packed {
        logic dir;
        logic fire;
        logic down;
        logic up;
        logic right;
        logic left;
    } btn_t;

    function automatic logic [4:0] rotl2(input logic [4:0] v);
        return {v[2:0], v[4:3]};
    endfunction

    state_t     state, state_n;
    btn_t       btn_cur, btn_prev, btn_edge;
    logic [4:0] lfsr, lfsr_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic       hit_q, hit_n;

    logic [4:0] x_n, rise_n, run_n, tx_n, ty_n;
    logic       dir_n, shoot_n;
    logic [7:0] score_n;
    logic [2:0] shots_n;

    assign btn_cur  = '{dir: btn_dir, fire: btn_fire, down: btn_down,
                        up: btn_up, right: btn_right, left: btn_left};
    assign btn_edge = btn_cur & ~btn_prev;
    assign lfsr_n   = {lfsr[3:0], lfsr[4] ^ lfsr[2]};

    assign busy      = (state == S_FIRE) || (state == S_WAIT);
    assign game_over = (state == S_OVER);

    // NOTE: every variable is given a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n    = state;
        x_n        = x_pos;
        rise_n     = rise_out;
        run_n      = run_out;
        dir_n      = direction_out;
        shoot_n    = 1'b0;
        score_n    = score;
        shots_n    = shots_left;
        tx_n       = target_x;
        ty_n       = target_y;
        wait_cnt_n = wait_cnt;
        hit_n      = hit_q;

        case (state)
            S_AIM: begin
                if (btn_edge.left ^ btn_edge.right) begin
                    if (!aim_sel) begin
                        if (btn_edge.left && x_pos != 5'd0)   x_n = x_pos - 5'd1;
                        if (btn_edge.right && x_pos != 5'd31) x_n = x_pos + 5'd1;
                    end else begin
                        if (btn_edge.left && run_out > 5'd1)               run_n = run_out - 5'd1;
                        if (btn_edge.right && run_out < 5'(RUN_MAX))       run_n = run_out + 5'd1;
                    end
                end
                // Rise stays within 1..31 so the downstream calculation always terminates.
                if (btn_edge.up ^ btn_edge.down) begin
                    if (btn_edge.up && rise_out != 5'd31) rise_n = rise_out + 5'd1;
                    if (btn_edge.down && rise_out > 5'd1) rise_n = rise_out - 5'd1;
                end
                if (btn_edge.dir) dir_n = ~direction_out;
                if (btn_edge.fire) begin
                    state_n = S_FIRE;
                    shoot_n = 1'b1;
                end
            end
            S_FIRE: begin
                state_n    = S_WAIT;
                wait_cnt_n = '0;
            end
            S_WAIT: begin
                wait_cnt_n = wait_cnt + CNT_W'(1);
                if (result_valid) begin
                    hit_n   = hit;
                    state_n = S_SCORE;
                end else if (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
                    hit_n   = 1'b0;
                    state_n = S_SCORE;
                end
            end
            S_SCORE: begin
                state_n = S_AIM;
                if (hit_q) begin
                    if (score != 8'hFF) score_n = score + 8'd1;
                    tx_n = lfsr;
                    ty_n = rotl2(lfsr);
                end else begin
                    shots_n = shots_left - 3'd1;
                    if (shots_left == 3'd1) state_n = S_OVER;
                end
            end
            S_OVER: begin
                if (btn_edge.fire) begin
                    state_n = S_AIM;
                    score_n = '0;
                    shots_n = 3'(SHOTS);
                    tx_n    = lfsr;
                    ty_n    = rotl2(lfsr);
                end
            end
            default: state_n = S_AIM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_AIM;
            // Held buttons must be released after reset before they count as a new press.
            btn_prev      <= '1;
            lfsr          <= LFSR_SEED;
            wait_cnt      <= '0;
            hit_q         <= 1'b0;
            x_pos         <= 5'd16;
            rise_out      <= 5'd1;
            run_out       <= 5'd1;
            direction_out <= 1'b1;
            shoot         <= 1'b0;
            score         <= '0;
            shots_left    <= 3'(SHOTS);
            target_x      <= LFSR_SEED;
            target_y      <= rotl2(LFSR_SEED);
        end else begin
            state         <= state_n;
            btn_prev      <= btn_cur;
            lfsr          <= lfsr_n;
            wait_cnt      <= wait_cnt_n;
            hit_q         <= hit_n;
            x_pos         <= x_n;
            rise_out      <= rise_n;
            run_out       <= run_n;
            direction_out <= dir_n;
            shoot         <= shoot_n;
            score         <= score_n;
            shots_left    <= shots_n;
            target_x      <= tx_n;
            target_y      <= ty_n;
        end
    end

endmodule
